ram_port_master: RTL and testbench
==================================

// Module: ram_port_master
// PURPOSE
//  Initiator for one port of the team's inferred dual-port block RAM (ena/wea/addr/din/dout).
//  Converts a valid/ready request stream (read or write) into RAM port cycles and returns
//  read data in order over a valid/ready response stream.
//  Hides the RAM read latency selected by SYNC_OUTPUT.
//  Also provides a hardware sweep that clears the whole RAM to INIT_VAL.
// PARAMETERS
//  WIDTH         8     data width; must match the attached RAM
//  DEPTH         64    RAM words; INIT sweep covers 0..DEPTH-1
//  LG_DEPTH      6     address width, log2(DEPTH)
//  INIT_VAL      8'd0  value written by the INIT sweep
//  SYNC_OUTPUT   1     1: RAM dout valid the cycle after en; 0: dout valid in the same cycle
//  RSP_DEPTH     4     response FIFO entries (power of 2, >=2)
//  LG_RSP_DEPTH  2     log2(RSP_DEPTH)
// PORTS
//  clk         in   1         single clock, all state on posedge
//  rst         in   1         asynchronous, active-high reset
//  init_start  in   1         pulse: start clear sweep (sampled in IDLE only)
//  init_busy   out  1         high while sweep in progress
//  req_valid   in   1         request present
//  req_ready   out  1         request accepted when valid&&ready
//  req_we      in   1         1 = write, 0 = read
//  req_addr    in   LG_DEPTH  word address
//  req_data    in   WIDTH     write data (ignored for reads)
//  rsp_valid   out  1         read data available
//  rsp_ready   in   1         consumer takes response when valid&&ready
//  rsp_data    out  WIDTH     read data, in request order
//  ram_en      out  1         to RAM en
//  ram_we      out  1         to RAM we
//  ram_addr    out  LG_DEPTH  to RAM addr
//  ram_din     out  WIDTH     to RAM din
//  ram_dout    in   WIDTH     from RAM dout
// BEHAVIOUR
//  - States: IDLE, INIT. Reset -> IDLE, sweep addr=0, FIFO empty, in-flight flag=0.
//    Reset outputs: init_busy=0, rsp_valid=0, req_ready=1, ram_en=0.
//  - IDLE & init_start -> INIT. init_start is ignored in INIT.
//  - INIT: ram_en=ram_we=1, ram_addr=sweep addr, ram_din=INIT_VAL, one word per cycle.
//    After writing DEPTH-1 -> IDLE, sweep addr reset to 0.
//    init_busy=1 for exactly DEPTH cycles; req_ready=0 throughout.
//  - Credits: occ = FIFO count + in-flight read (SYNC_OUTPUT=1 only).
//    req_ready = (state==IDLE) && (occ < RSP_DEPTH). It applies to writes too and
//    never depends on req_valid or req_we.
//  - RAM drive is combinational from the accept term.
//    ram_en = accept | INIT; ram_we = (accept & req_we) | INIT.
//    ram_addr/ram_din = request fields in IDLE, sweep values in INIT.
//    When idle: ram_en=0, and addr/din may hold any value.
//  - Read capture:
//    SYNC_OUTPUT=1: accepted read sets the in-flight flag; ram_dout is pushed at t+1.
//    SYNC_OUTPUT=0: ram_dout is pushed at t (the accept cycle).
//  - Latency from accept to rsp_valid with FIFO empty: 2 cycles (SYNC=1), 1 cycle (SYNC=0).
//  - FIFO is first-word-visible: rsp_valid = count!=0; rsp_data = head entry.
//    Push and pop in the same cycle leave count unchanged. Pointers wrap mod RSP_DEPTH.
//    Overflow is impossible by the credit rule. A pop while empty is a no-op.
//  - A write followed by a read to the same address on the next cycle returns the new data.
//  - Reads still in flight when INIT starts complete normally and return pre-sweep data.
//  - Reset asserted mid-operation: the FIFO, in-flight read and any sweep are discarded
//    immediately (async). Outputs return to reset values in the same cycle.
// TESTING
//  1 Assert rst mid-cycle -> immediately rsp_valid=0, init_busy=0, req_ready=1, ram_en=0.
//  2 SYNC=1: write 0xA5 @3, then read @3 next cycle.
//    -> ram_we=1 only on the write; rsp_valid=1 with 0xA5 exactly 2 cycles after the read accept.
//  3 rsp_ready=0, offer 6 reads @0..5 -> 4 accepted, then req_ready=0.
//    Raise rsp_ready -> data for @0..3 in order, then @4 and @5 accepted.
//  4 init_start pulse -> init_busy=1 for 64 cycles with ram_addr 0..63 and ram_din=0x00.
//    Afterwards, a read @3 returns 0x00.
//  5 rsp_ready=1 with back-to-back reads every cycle -> one response per cycle and
//    req_ready held at 1 (repeat with SYNC_OUTPUT=0: latency 1).
//  6 Queue 2 responses, assert rst -> rsp_valid=0 at once.
//    After release, the FIFO stays empty until a new read is issued.

Source files
------------

// File: rtl/ram_port_master.sv
// Single-port initiator for the inferred block RAM: valid/ready requests in, in-order read
// responses out through a small FIFO, plus a hardware sweep that clears every word.
module ram_port_master #(
    parameter int              WIDTH        = 8,
    parameter int              DEPTH        = 64,
    parameter int              LG_DEPTH     = 6,
    parameter logic [WIDTH-1:0] INIT_VAL    = '0,
    parameter bit              SYNC_OUTPUT  = 1'b1,
    parameter int              RSP_DEPTH    = 4,
    parameter int              LG_RSP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_start,
    output logic                init_busy,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [LG_DEPTH-1:0] req_addr,
    input  logic [WIDTH-1:0]    req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                ram_en,
    output logic                ram_we,
    output logic [LG_DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0]    ram_din,
    input  logic [WIDTH-1:0]    ram_dout
);

    typedef enum logic [0:0] {IDLE, INIT} state_t;

    localparam logic [LG_RSP_DEPTH:0] RSP_FULL  = (LG_RSP_DEPTH+1)'(RSP_DEPTH);
    localparam logic [LG_DEPTH-1:0]   LAST_ADDR = LG_DEPTH'(DEPTH - 1);

    state_t                    state;
    logic [LG_DEPTH-1:0]       sweep_addr;
    logic                      inflight;
    logic [WIDTH-1:0]          fifo_mem [RSP_DEPTH];
    logic [LG_RSP_DEPTH-1:0]   wr_ptr;
    logic [LG_RSP_DEPTH-1:0]   rd_ptr;
    logic [LG_RSP_DEPTH:0]     count;
    logic [LG_RSP_DEPTH:0]     occ;
    logic                      accept;
    logic                      push;
    logic                      pop;

    // A read still travelling through the RAM output register already owns a FIFO slot.
    assign occ       = count + {{LG_RSP_DEPTH{1'b0}}, (SYNC_OUTPUT ? inflight : 1'b0)};
    assign init_busy = (state == INIT);
    assign req_ready = (state == IDLE) && (occ < RSP_FULL);
    assign accept    = req_valid && req_ready;

    assign ram_en   = accept || init_busy;
    assign ram_we   = (accept && req_we) || init_busy;
    assign ram_addr = init_busy ? sweep_addr : req_addr;
    assign ram_din  = init_busy ? INIT_VAL : req_data;

    assign push      = SYNC_OUTPUT ? inflight : (accept && !req_we);
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= ram_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sweep_addr <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            inflight <= SYNC_OUTPUT && accept && !req_we;

            if (push)
                wr_ptr <= wr_ptr + LG_RSP_DEPTH'(1);
            if (pop)
                rd_ptr <= rd_ptr + LG_RSP_DEPTH'(1);

            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            case (state)
                IDLE: begin
                    if (init_start)
                        state <= INIT;
                end
                INIT: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        sweep_addr <= '0;
                    end else begin
                        sweep_addr <= sweep_addr + LG_DEPTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master: one instance with a registered-output RAM model,
// one with a combinational-read RAM model, sharing the request/response stimulus.
module tb_ram_port_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_start = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       rsp_ready = 1'b0;

    logic       a_init_busy, a_req_ready, a_rsp_valid, a_ram_en, a_ram_we;
    logic [7:0] a_rsp_data, a_ram_din, a_ram_dout;
    logic [5:0] a_ram_addr;
    logic       b_init_busy, b_req_ready, b_rsp_valid, b_ram_en, b_ram_we;
    logic [7:0] b_rsp_data, b_ram_din, b_ram_dout;
    logic [5:0] b_ram_addr;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];

    int n_vec = 0;
    int n_err = 0;

    ram_port_master #(.SYNC_OUTPUT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(a_init_busy),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_din(a_ram_din), .ram_dout(a_ram_dout)
    );

    ram_port_master #(.SYNC_OUTPUT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .init_start(init_start), .init_busy(b_init_busy),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    always #5 clk = ~clk;

    // Read-first RAM with registered dout.
    always @(posedge clk) begin
        if (a_ram_en) begin
            if (a_ram_we)
                mem_a[a_ram_addr] <= a_ram_din;
            a_ram_dout <= mem_a[a_ram_addr];
        end
    end

    // RAM with combinational read.
    always @(posedge clk) begin
        if (b_ram_en && b_ram_we)
            mem_b[b_ram_addr] <= b_ram_din;
    end
    assign b_ram_dout = mem_b[b_ram_addr];

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", a_rsp_valid); end
        n_vec++; if (a_init_busy !== 1'b0) begin n_err++; $display("FAIL reset_init_busy: got %b want 0", a_init_busy); end
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", a_req_ready); end
        n_vec++; if (a_ram_en !== 1'b0) begin n_err++; $display("FAIL reset_ram_en: got %b want 0", a_ram_en); end
        next();
        rst = 1'b0;
        next();
    endtask

    task automatic test_reset_mid_sweep();
        init_start = 1'b1;
        next();
        init_start = 1'b0;
        repeat (4) next();
        #3;
        n_vec++; if (a_init_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", a_init_busy); end
        n_vec++; if (a_ram_addr !== 6'd4) begin n_err++; $display("FAIL mid_addr: got %0d want 4", a_ram_addr); end
        rst = 1'b1;
        #1;
        n_vec++; if (a_init_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", a_init_busy); end
        n_vec++; if (a_ram_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_ram_en: got %b want 0", a_ram_en); end
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_req_ready: got %b want 1", a_req_ready); end
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_rsp_valid: got %b want 0", a_rsp_valid); end
        next();
        rst = 1'b0;
        #3;
        n_vec++; if (a_init_busy !== 1'b0) begin n_err++; $display("FAIL mid_after_busy: got %b want 0", a_init_busy); end
        next();
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd3; req_data = 8'hA5;
        #3;
        n_vec++; if (a_ram_en !== 1'b1) begin n_err++; $display("FAIL wr_ram_en: got %b want 1", a_ram_en); end
        n_vec++; if (a_ram_we !== 1'b1) begin n_err++; $display("FAIL wr_ram_we: got %b want 1", a_ram_we); end
        n_vec++; if (a_ram_addr !== 6'd3) begin n_err++; $display("FAIL wr_ram_addr: got %0d want 3", a_ram_addr); end
        n_vec++; if (a_ram_din !== 8'hA5) begin n_err++; $display("FAIL wr_ram_din: got %h want a5", a_ram_din); end
        next();
        req_we = 1'b0;
        #3;
        n_vec++; if (a_ram_en !== 1'b1) begin n_err++; $display("FAIL rd_ram_en: got %b want 1", a_ram_en); end
        n_vec++; if (a_ram_we !== 1'b0) begin n_err++; $display("FAIL rd_ram_we: got %b want 0", a_ram_we); end
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_lat0: got %b want 0", a_rsp_valid); end
        next();
        req_valid = 1'b0;
        #3;
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_lat1: got %b want 0", a_rsp_valid); end
        n_vec++; if (a_ram_en !== 1'b0) begin n_err++; $display("FAIL idle_ram_en: got %b want 0", a_ram_en); end
        next();
        #3;
        n_vec++; if (a_rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_lat2_valid: got %b want 1", a_rsp_valid); end
        n_vec++; if (a_rsp_data !== 8'hA5) begin n_err++; $display("FAIL rd_lat2_data: got %h want a5", a_rsp_data); end
        next();
        #3;
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_popped: got %b want 0", a_rsp_valid); end
        next();
    endtask

    task automatic test_backpressure();
        int acc;
        int got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 6'(i); req_data = 8'(8'h10 + i);
            #3;
            n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL bp_wr_ready: got %b want 1", a_req_ready); end
            next();
        end
        req_we = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_addr = 6'(acc);
            #3;
            if (a_req_ready) acc++;
            next();
        end
        req_valid = 1'b0;
        #3;
        n_vec++; if (acc !== 4) begin n_err++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        n_vec++; if (a_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", a_req_ready); end
        next();
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            req_valid = (acc < 6);
            req_addr = 6'(acc);
            #3;
            if (a_rsp_valid) begin
                n_vec++;
                if (a_rsp_data !== 8'(8'h10 + got)) begin
                    n_err++; $display("FAIL bp_order[%0d]: got %h want %h", got, a_rsp_data, 8'(8'h10 + got));
                end
                got++;
            end
            if (a_req_ready && acc < 6) acc++;
            next();
        end
        req_valid = 1'b0;
        n_vec++; if (got !== 6) begin n_err++; $display("FAIL bp_responses: got %0d want 6", got); end
        n_vec++; if (acc !== 6) begin n_err++; $display("FAIL bp_total_accepted: got %0d want 6", acc); end
        next();
    endtask

    task automatic test_init();
        int lat;
        req_valid = 1'b0;
        init_start = 1'b1;
        #3;
        n_vec++; if (a_init_busy !== 1'b0) begin n_err++; $display("FAIL init_pre_busy: got %b want 0", a_init_busy); end
        next();
        for (int k = 0; k < 64; k++) begin
            init_start = (k == 10);
            #3;
            n_vec++; if (a_init_busy !== 1'b1) begin n_err++; $display("FAIL init_busy[%0d]: got %b want 1", k, a_init_busy); end
            n_vec++; if (a_ram_addr !== 6'(k)) begin n_err++; $display("FAIL init_addr[%0d]: got %0d want %0d", k, a_ram_addr, k); end
            n_vec++; if (a_ram_din !== 8'h00) begin n_err++; $display("FAIL init_din[%0d]: got %h want 00", k, a_ram_din); end
            n_vec++; if (a_ram_en !== 1'b1 || a_ram_we !== 1'b1) begin n_err++; $display("FAIL init_en_we[%0d]: got %b%b want 11", k, a_ram_en, a_ram_we); end
            n_vec++; if (a_req_ready !== 1'b0) begin n_err++; $display("FAIL init_ready[%0d]: got %b want 0", k, a_req_ready); end
            next();
        end
        #3;
        n_vec++; if (a_init_busy !== 1'b0) begin n_err++; $display("FAIL init_done_busy: got %b want 0", a_init_busy); end
        next();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3;
        #3;
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL init_rd_ready: got %b want 1", a_req_ready); end
        next();
        req_valid = 1'b0;
        lat = -1;
        for (int c = 0; c < 5 && lat < 0; c++) begin
            #3;
            if (a_rsp_valid) begin
                lat = c;
                n_vec++; if (a_rsp_data !== 8'h00) begin n_err++; $display("FAIL init_rd_data: got %h want 00", a_rsp_data); end
            end
            next();
        end
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL init_rd_latency: got %0d want 1", lat); end
    endtask

    task automatic test_back_to_back();
        logic a_exp;
        logic b_exp;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 6'(i); req_data = 8'(8'h30 + i);
            next();
        end
        req_we = 1'b0;
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8);
            req_addr = 6'(k);
            #3;
            if (k < 8) begin
                n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_a_ready[%0d]: got %b want 1", k, a_req_ready); end
                n_vec++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_b_ready[%0d]: got %b want 1", k, b_req_ready); end
            end
            a_exp = (k >= 2 && k <= 9);
            b_exp = (k >= 1 && k <= 8);
            n_vec++; if (a_rsp_valid !== a_exp) begin n_err++; $display("FAIL b2b_a_valid[%0d]: got %b want %b", k, a_rsp_valid, a_exp); end
            n_vec++; if (b_rsp_valid !== b_exp) begin n_err++; $display("FAIL b2b_b_valid[%0d]: got %b want %b", k, b_rsp_valid, b_exp); end
            if (a_exp) begin
                n_vec++; if (a_rsp_data !== 8'(8'h30 + k - 2)) begin n_err++; $display("FAIL b2b_a_data[%0d]: got %h want %h", k, a_rsp_data, 8'(8'h30 + k - 2)); end
            end
            if (b_exp) begin
                n_vec++; if (b_rsp_data !== 8'(8'h30 + k - 1)) begin n_err++; $display("FAIL b2b_b_data[%0d]: got %h want %h", k, b_rsp_data, 8'(8'h30 + k - 1)); end
            end
            next();
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_flush();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd0;
        next();
        req_addr = 6'd1;
        next();
        req_valid = 1'b0;
        next();
        #3;
        n_vec++; if (a_rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_a_queued: got %b want 1", a_rsp_valid); end
        n_vec++; if (b_rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_b_queued: got %b want 1", b_rsp_valid); end
        rst = 1'b1;
        #1;
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_a_rst_valid: got %b want 0", a_rsp_valid); end
        n_vec++; if (b_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_b_rst_valid: got %b want 0", b_rsp_valid); end
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL flush_rst_ready: got %b want 1", a_req_ready); end
        next();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_a_empty[%0d]: got %b want 0", c, a_rsp_valid); end
            n_vec++; if (b_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_b_empty[%0d]: got %b want 0", c, b_rsp_valid); end
            next();
        end
        req_valid = 1'b1; req_addr = 6'd2;
        next();
        req_valid = 1'b0;
        #3;
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_err++; $display("FAIL flush_a_lat1: got %b want 0", a_rsp_valid); end
        n_vec++; if (b_rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_b_valid: got %b want 1", b_rsp_valid); end
        n_vec++; if (b_rsp_data !== 8'h32) begin n_err++; $display("FAIL flush_b_data: got %h want 32", b_rsp_data); end
        next();
        #3;
        n_vec++; if (a_rsp_valid !== 1'b1) begin n_err++; $display("FAIL flush_a_valid: got %b want 1", a_rsp_valid); end
        n_vec++; if (a_rsp_data !== 8'h32) begin n_err++; $display("FAIL flush_a_data: got %h want 32", a_rsp_data); end
        next();
    endtask

    initial begin
        #3;
        test_reset();
        test_reset_mid_sweep();
        test_write_read();
        test_backpressure();
        test_init();
        test_back_to_back();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
